dmem_bridge: RTL and testbench
==============================

DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of BUSY cycles waiting for bus_ack before an access faults (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port mem_valid, input, 1, core requests a load/store this cycle.
REQ-005 SHALL have port data_mem_write_enable, input, 1, 1 = store, 0 = load.
REQ-006 SHALL have port ALUResult, input, 32, byte address.
REQ-007 SHALL have port data_mem_write_data, input, 32, store data, LSB-aligned.
REQ-008 SHALL have port funct3, input, 3, access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-009 SHALL have port data_mem_read_data, output, 32, extended load result, registered.
REQ-010 SHALL have port stall, output, 1, core must hold PC and inputs while high.
REQ-011 SHALL have port fault, output, 1, one-cycle pulse on a misaligned, illegal, error or timed-out access.
REQ-012 SHALL have bus ports: bus_req out 1, bus_we out 1, bus_addr out 32 (word-aligned, [1:0]=00), bus_wdata out 32, bus_be out 4, bus_ack in 1, bus_err in 1, bus_rdata in 32.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 IDLE: mem_valid=1 with legal funct3 and aligned address SHALL latch address, write data, byte enables, funct3 and we, and go to BUSY.
REQ-015 stall SHALL equal (IDLE and mem_valid and legal and aligned) or BUSY; stall SHALL be 0 in DONE.
REQ-016 Alignment: H/HU requires addr[0]=0; W requires addr[1:0]=00; B/BU is always aligned.
REQ-017 A misaligned access or illegal funct3 (011, 110, 111) in IDLE SHALL cause no bus request, stall=0, and fault=1 in the next cycle.
REQ-018 BUSY: bus_req SHALL be 1 and bus_we/addr/wdata/be SHALL be held stable until the cycle bus_ack=1 is sampled.
REQ-019 bus_ack=1 in BUSY SHALL go to DONE next cycle; bus_req SHALL be 0 in DONE.
REQ-020 Store byte-lane rules: B: wdata={4{byte}}, be=0001<<addr[1:0]. H: wdata={2{half}}, be=0011 (addr[1]=0) or 1100 (addr[1]=1). W: wdata=full word, be=1111.
REQ-021 Load extraction on ack: B/BU selects byte addr[1:0], sign-/zero-extended; H/HU selects half addr[1], extended; W takes the full word. Result is registered into data_mem_read_data, valid in DONE and held until the next load completes.
REQ-022 A store SHALL NOT change data_mem_read_data.
REQ-023 bus_err=1 together with bus_ack SHALL go to DONE with fault=1 during DONE; a load SHALL then write 0 to data_mem_read_data.
REQ-024 Timeout counter SHALL clear on BUSY entry and increment each BUSY cycle without ack.
REQ-025 Reaching TIMEOUT_CYCLES SHALL drop bus_req, go to DONE with fault=1, and read data 0 for loads.
REQ-026 bus_ack in the same cycle the counter reaches the limit SHALL take priority: normal completion, no fault.
REQ-027 DONE SHALL always return to IDLE after exactly one cycle; mem_valid sampled in DONE SHALL be ignored (core advances on that edge).
REQ-028 Minimum latency: request cycle (stall=1) -> BUSY -> DONE, i.e. 2 stall cycles when bus_ack is returned in the first BUSY cycle.
REQ-029 bus_ack outside BUSY SHALL be ignored.

Reset
REQ-030 reset=1 at a rising edge SHALL force IDLE and set timeout counter=0, bus_req=0, fault=0, data_mem_read_data=0, and bus_addr/wdata/be/we=0.
REQ-031 reset asserted during BUSY SHALL abandon the access: bus_req=0 from the next cycle, and a late bus_ack SHALL be ignored.

Verification
- LW addr 0x100, bus_rdata=0xDEADBEEF, ack in 1st BUSY cycle -> stall high 2 cycles, read_data=0xDEADBEEF in DONE, fault=0.
- LB addr 0x103, rdata=0x80FF_0000 -> read_data=0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x000080FF.
- SB addr 0x201 data 0x000000AB -> bus_be=0010, bus_wdata=0xABABABAB, bus_we=1, held stable across 3 wait cycles until ack.
- LW addr 0x102 -> no bus_req, stall=0, fault pulse 1 cycle; funct3=011 -> same response.
- TIMEOUT_CYCLES=4, no ack -> bus_req high exactly 4 cycles, then DONE with fault=1, read_data=0; repeat with ack on the 4th cycle -> no fault.
- reset in 2nd BUSY cycle, then ack -> bus_req=0, state IDLE, read_data=0, fault=0.

Source files
------------

// File: rtl/dmem_bridge.sv
// dmem_bridge: bridges a single-issue core's load/store port onto a simple
// word-wide req/ack bus. Stores are lane-replicated with byte enables; loads
// are lane-selected and sign/zero extended. Alignment and funct3 are checked
// before any bus activity, and a bounded wait on bus_ack turns into a fault.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   mem_valid             : core presents a load/store this cycle
//   data_mem_write_enable : 1 = store, 0 = load
//   ALUResult             : byte address
//   data_mem_write_data   : store data, LSB-aligned
//   funct3                : size/sign (B, H, W, BU, HU)
//   data_mem_read_data    : extended load result (registered)
//   stall                 : core holds PC and inputs while high
//   fault                 : one-cycle pulse on misaligned/illegal/error/timeout
//   bus_*                 : word-aligned request bus towards memory
module dmem_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_valid,
   input  logic        data_mem_write_enable,
   input  logic [31:0] ALUResult,
   input  logic [31:0] data_mem_write_data,
   input  logic [2:0]  funct3,
   output logic [31:0] data_mem_read_data,
   output logic        stall,
   output logic        fault,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   input  logic        bus_ack,
   input  logic        bus_err,
   input  logic [31:0] bus_rdata
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              bus_req_q, bus_req_d;
   logic              bus_we_q, bus_we_d;
   logic [31:0]       bus_addr_q, bus_addr_d;
   logic [31:0]       bus_wdata_q, bus_wdata_d;
   logic [3:0]        bus_be_q, bus_be_d;
   logic [1:0]        off_q, off_d;
   logic [2:0]        f3_q, f3_d;
   logic [31:0]       rd_q, rd_d;
   logic              fault_q, fault_d;

   logic              legal_c;
   logic              aligned_c;
   logic              accept_c;
   logic [3:0]        be_c;
   logic [31:0]       wdata_c;
   logic [31:0]       load_c;
   logic [7:0]        byte_c;
   logic [15:0]       half_c;

   // Request decode: legality, alignment, lane enables and replicated store data
   always_comb begin
      legal_c   = 1'b0;
      aligned_c = 1'b0;
      be_c      = 4'b1111;
      wdata_c   = data_mem_write_data;
      case (funct3)
         3'b000, 3'b100: legal_c = 1'b1;
         3'b001, 3'b101: legal_c = 1'b1;
         3'b010:         legal_c = 1'b1;
         default:        legal_c = 1'b0;
      endcase
      case (funct3[1:0])
         2'b00: begin
            aligned_c = 1'b1;
            be_c      = 4'b0001 << ALUResult[1:0];
            wdata_c   = {4{data_mem_write_data[7:0]}};
         end
         2'b01: begin
            aligned_c = ~ALUResult[0];
            be_c      = ALUResult[1] ? 4'b1100 : 4'b0011;
            wdata_c   = {2{data_mem_write_data[15:0]}};
         end
         default: begin
            aligned_c = (ALUResult[1:0] == 2'b00);
            be_c      = 4'b1111;
            wdata_c   = data_mem_write_data;
         end
      endcase
      accept_c = mem_valid & legal_c & aligned_c;
   end

   // Load lane select and extension, using the offset latched at request time
   always_comb begin
      byte_c = bus_rdata[{off_q, 3'b000} +: 8];
      half_c = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (f3_q[1:0])
         2'b00:   load_c = {{24{~f3_q[2] & byte_c[7]}}, byte_c};
         2'b01:   load_c = {{16{~f3_q[2] & half_c[15]}}, half_c};
         default: load_c = bus_rdata;
      endcase
   end

   // Next-state and next-register logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bus_req_d   = 1'b0;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_be_d    = bus_be_q;
      off_d       = off_q;
      f3_d        = f3_q;
      rd_d        = rd_q;
      fault_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept_c) begin
               state_d     = BUSY;
               cnt_d       = '0;
               bus_req_d   = 1'b1;
               bus_we_d    = data_mem_write_enable;
               bus_addr_d  = {ALUResult[31:2], 2'b00};
               bus_wdata_d = wdata_c;
               bus_be_d    = be_c;
               off_d       = ALUResult[1:0];
               f3_d        = funct3;
            end else if (mem_valid) begin
               // Rejected before touching the bus; fault shows up next cycle
               fault_d = 1'b1;
            end
         end
         BUSY: begin
            // Ack wins over a timeout landing in the same cycle
            if (bus_ack) begin
               state_d = DONE;
               fault_d = bus_err;
               if (!bus_we_q) begin
                  rd_d = bus_err ? 32'd0 : load_c;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d = DONE;
               fault_d = 1'b1;
               if (!bus_we_q) begin
                  rd_d = 32'd0;
               end
            end else begin
               cnt_d     = cnt_q + CNT_W'(1);
               bus_req_d = 1'b1;
            end
         end
         DONE: begin
            // Core advances on this edge, so mem_valid here is not a new request
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_be_q    <= '0;
         off_q       <= '0;
         f3_q        <= '0;
         rd_q        <= '0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_be_q    <= bus_be_d;
         off_q       <= off_d;
         f3_q        <= f3_d;
         rd_q        <= rd_d;
         fault_q     <= fault_d;
      end
   end

   // Stall covers the accepting IDLE cycle, so it must see the live request
   assign stall              = ((state_q == IDLE) & accept_c) | (state_q == BUSY);
   assign fault              = fault_q;
   assign data_mem_read_data = rd_q;
   assign bus_req            = bus_req_q;
   assign bus_we             = bus_we_q;
   assign bus_addr           = bus_addr_q;
   assign bus_wdata          = bus_wdata_q;
   assign bus_be             = bus_be_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Testbench for dmem_bridge (TIMEOUT_CYCLES=4): directed scenarios plus a
// randomized run compared against an arithmetic reference model.
module tb_dmem_bridge;

   localparam int unsigned TMO = 4;

   logic        clk;
   logic        reset;
   logic        mem_valid;
   logic        data_mem_write_enable;
   logic [31:0] ALUResult;
   logic [31:0] data_mem_write_data;
   logic [2:0]  funct3;
   logic [31:0] data_mem_read_data;
   logic        stall;
   logic        fault;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack;
   logic        bus_err;
   logic [31:0] bus_rdata;

   int errors;
   int checks;
   logic [31:0] exp_rd;

   dmem_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk                   (clk),
      .reset                 (reset),
      .mem_valid             (mem_valid),
      .data_mem_write_enable (data_mem_write_enable),
      .ALUResult             (ALUResult),
      .data_mem_write_data   (data_mem_write_data),
      .funct3                (funct3),
      .data_mem_read_data    (data_mem_read_data),
      .stall                 (stall),
      .fault                 (fault),
      .bus_req               (bus_req),
      .bus_we                (bus_we),
      .bus_addr              (bus_addr),
      .bus_wdata             (bus_wdata),
      .bus_be                (bus_be),
      .bus_ack               (bus_ack),
      .bus_err               (bus_err),
      .bus_rdata             (bus_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic is_legal(input logic [2:0] f3);
      return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
   endfunction

   function automatic logic is_aligned(input logic [2:0] f3, input logic [31:0] addr);
      int n;
      n = 1 << int'(f3[1:0]);
      return (int'(addr[1:0]) % n) == 0;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] rdata);
      logic [31:0] v;
      int sh;
      v = rdata;
      if (f3[1:0] == 2'd0) begin
         sh = 8 * int'(addr[1:0]);
         v = (rdata >> sh) & 32'h0000_00FF;
         if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
      end else if (f3[1:0] == 2'd1) begin
         sh = 16 * int'(addr[1]);
         v = (rdata >> sh) & 32'h0000_FFFF;
         if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
      end
      return v;
   endfunction

   function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
      int n;
      int m;
      n = 1 << int'(f3[1:0]);
      m = ((1 << n) - 1) << int'(addr[1:0]);
      return 4'(m);
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
      if (f3[1:0] == 2'd0) return 32'(wd[7:0]) * 32'h0101_0101;
      if (f3[1:0] == 2'd1) return 32'(wd[15:0]) * 32'h0001_0001;
      return wd;
   endfunction

   // ---------------- stimulus driver ----------------
   // Presents one access, answers the bus, and reports what was observed.
   task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [2:0] f3, input int ack_at, input logic err,
                             input logic [31:0] rdata, input logic spur,
                             output int stall_n, output int busy_n, output int fault_n,
                             output logic [31:0] rd_done, output logic fault_done,
                             output logic [3:0] be_o, output logic [31:0] wd_o,
                             output logic [31:0] addr_o, output logic we_o,
                             output logic stable);
      int  k;
      int  post;
      logic done;
      stall_n = 0; busy_n = 0; fault_n = 0;
      rd_done = 32'hx; fault_done = 1'bx;
      be_o = 4'h0; wd_o = 32'h0; addr_o = 32'h0; we_o = 1'b0; stable = 1'b1;
      done = 1'b0; post = 0; k = 0;
      @(posedge clk); #1;
      mem_valid = 1'b1;
      data_mem_write_enable = we;
      ALUResult = addr;
      data_mem_write_data = wd;
      funct3 = f3;
      bus_rdata = rdata;
      while (post < 2 && k < 60) begin
         @(negedge clk);
         if (stall) stall_n++;
         if (fault) fault_n++;
         if (bus_req) begin
            busy_n++;
            if (busy_n == 1) begin
               be_o = bus_be; wd_o = bus_wdata; addr_o = bus_addr; we_o = bus_we;
            end else if (bus_be !== be_o || bus_wdata !== wd_o || bus_addr !== addr_o ||
                         bus_we !== we_o) begin
               stable = 1'b0;
            end
            bus_ack = (busy_n == ack_at);
            bus_err = (busy_n == ack_at) && err;
         end else begin
            bus_ack = spur;
            bus_err = 1'b0;
         end
         if (done) post++;
         else if (!stall) begin
            done = 1'b1;
            rd_done = data_mem_read_data;
            fault_done = fault;
         end
         @(posedge clk); #1;
         bus_ack = 1'b0;
         bus_err = 1'b0;
         if (done) mem_valid = 1'b0;
         k++;
      end
      mem_valid = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      mem_valid = 1'b0; data_mem_write_enable = 1'b0; ALUResult = 32'h0;
      data_mem_write_data = 32'h0; funct3 = 3'd0;
      bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req: got %b want 0", bus_req); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", fault); end
      checks++; if (data_mem_read_data !== 32'h0) begin errors++; $display("FAIL reset_rd: got %h want 0", data_mem_read_data); end
      checks++; if ({bus_addr, bus_wdata, bus_be, bus_we} !== 69'h0) begin
         errors++; $display("FAIL reset_bus_fields: got addr=%h wdata=%h be=%b we=%b want all 0",
                            bus_addr, bus_wdata, bus_be, bus_we);
      end
      exp_rd = 32'h0;
   endtask

   task automatic test_load_basic();
      int s, b, f; logic [31:0] rd, wo, ao; logic fd, we_o, st; logic [3:0] be;
      run_access(1'b0, 32'h100, 32'h0, 3'd2, 1, 1'b0, 32'hDEAD_BEEF, 1'b0,
                 s, b, f, rd, fd, be, wo, ao, we_o, st);
      exp_rd = 32'hDEAD_BEEF;
      checks++; if (s != 2) begin errors++; $display("FAIL lw_stall_cycles: got %0d want 2", s); end
      checks++; if (rd !== exp_rd) begin errors++; $display("FAIL lw_data: got %h want %h", rd, exp_rd); end
      checks++; if (f != 0) begin errors++; $display("FAIL lw_fault: got %0d pulses want 0", f); end
      checks++; if (ao !== 32'h100 || we_o !== 1'b0) begin errors++; $display("FAIL lw_bus: got addr=%h we=%b want 100/0", ao, we_o); end
   endtask

   task automatic test_load_ext();
      logic [2:0]  f3s [3] = '{3'd0, 3'd4, 3'd5};
      logic [31:0] ads [3] = '{32'h103, 32'h103, 32'h102};
      logic [31:0] exs [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF};
      for (int i = 0; i < 3; i++) begin
         int s, b, f; logic [31:0] rd, wo, ao; logic fd, we_o, st; logic [3:0] be;
         run_access(1'b0, ads[i], 32'h0, f3s[i], 1, 1'b0, 32'h80FF_0000, 1'b0,
                    s, b, f, rd, fd, be, wo, ao, we_o, st);
         exp_rd = exs[i];
         checks++; if (rd !== exp_rd) begin errors++; $display("FAIL load_ext_%0d: got %h want %h", i, rd, exp_rd); end
         checks++; if (ao !== 32'h100) begin errors++; $display("FAIL load_ext_addr_%0d: got %h want 00000100", i, ao); end
      end
   endtask

   task automatic test_store();
      int s, b, f; logic [31:0] rd, wo, ao; logic fd, we_o, st; logic [3:0] be;
      run_access(1'b1, 32'h201, 32'h0000_00AB, 3'd0, 4, 1'b0, 32'h5555_5555, 1'b1,
                 s, b, f, rd, fd, be, wo, ao, we_o, st);
      checks++; if (be !== 4'b0010) begin errors++; $display("FAIL sb_be: got %b want 0010", be); end
      checks++; if (wo !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata: got %h want abababab", wo); end
      checks++; if (we_o !== 1'b1 || ao !== 32'h200) begin errors++; $display("FAIL sb_we_addr: got we=%b addr=%h want 1/200", we_o, ao); end
      checks++; if (st !== 1'b1 || b != 4) begin errors++; $display("FAIL sb_stable: got stable=%b busy=%0d want 1/4", st, b); end
      checks++; if (rd !== exp_rd || f != 0) begin errors++; $display("FAIL sb_no_rd_change: got rd=%h faults=%0d want %h/0", rd, f, exp_rd); end
   endtask

   task automatic test_misaligned();
      logic [2:0]  f3s [2] = '{3'd2, 3'd3};
      logic [31:0] ads [2] = '{32'h102, 32'h100};
      for (int i = 0; i < 2; i++) begin
         int s, b, f; logic [31:0] rd, wo, ao; logic fd, we_o, st; logic [3:0] be;
         run_access(1'b0, ads[i], 32'h0, f3s[i], 1, 1'b0, 32'h1234_5678, 1'b0,
                    s, b, f, rd, fd, be, wo, ao, we_o, st);
         checks++; if (s != 0 || b != 0) begin errors++; $display("FAIL reject_%0d_nobus: got stall=%0d busy=%0d want 0/0", i, s, b); end
         checks++; if (f != 1 || fd !== 1'b0) begin errors++; $display("FAIL reject_%0d_fault: got pulses=%0d same_cycle=%b want 1/0", i, f, fd); end
         checks++; if (rd !== exp_rd) begin errors++; $display("FAIL reject_%0d_rd: got %h want %h", i, rd, exp_rd); end
      end
   endtask

   task automatic test_timeout();
      int s, b, f; logic [31:0] rd, wo, ao; logic fd, we_o, st; logic [3:0] be;
      run_access(1'b0, 32'h300, 32'h0, 3'd2, 0, 1'b0, 32'hCAFE_F00D, 1'b0,
                 s, b, f, rd, fd, be, wo, ao, we_o, st);
      exp_rd = 32'h0;
      checks++; if (b != TMO) begin errors++; $display("FAIL tmo_req_cycles: got %0d want %0d", b, TMO); end
      checks++; if (fd !== 1'b1 || f != 1) begin errors++; $display("FAIL tmo_fault: got done=%b pulses=%0d want 1/1", fd, f); end
      checks++; if (rd !== exp_rd) begin errors++; $display("FAIL tmo_rd: got %h want 0", rd); end
      run_access(1'b0, 32'h304, 32'h0, 3'd2, TMO, 1'b0, 32'h1234_5678, 1'b0,
                 s, b, f, rd, fd, be, wo, ao, we_o, st);
      exp_rd = 32'h1234_5678;
      checks++; if (f != 0 || b != TMO) begin errors++; $display("FAIL tmo_ack_last: got pulses=%0d busy=%0d want 0/%0d", f, b, TMO); end
      checks++; if (rd !== exp_rd) begin errors++; $display("FAIL tmo_ack_last_rd: got %h want %h", rd, exp_rd); end
   endtask

   task automatic test_bus_err();
      int s, b, f; logic [31:0] rd, wo, ao; logic fd, we_o, st; logic [3:0] be;
      run_access(1'b0, 32'h402, 32'h0, 3'd1, 2, 1'b1, 32'hFFFF_FFFF, 1'b0,
                 s, b, f, rd, fd, be, wo, ao, we_o, st);
      exp_rd = 32'h0;
      checks++; if (fd !== 1'b1 || f != 1) begin errors++; $display("FAIL err_fault: got done=%b pulses=%0d want 1/1", fd, f); end
      checks++; if (rd !== exp_rd) begin errors++; $display("FAIL err_rd: got %h want 0", rd); end
   endtask

   task automatic test_reset_busy();
      // Put a nonzero value in read data first so the reset clear is visible
      int s, b, f; logic [31:0] rd, wo, ao; logic fd, we_o, st; logic [3:0] be;
      run_access(1'b0, 32'h500, 32'h0, 3'd2, 1, 1'b0, 32'hA5A5_0001, 1'b0,
                 s, b, f, rd, fd, be, wo, ao, we_o, st);
      @(posedge clk); #1;
      mem_valid = 1'b1; data_mem_write_enable = 1'b0; ALUResult = 32'h100; funct3 = 3'd2;
      bus_rdata = 32'h7777_7777;
      @(posedge clk); #1;           // BUSY cycle 1
      @(posedge clk); #1;           // BUSY cycle 2
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; mem_valid = 1'b0; bus_ack = 1'b1;
      @(negedge clk);
      checks++; if (bus_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rst_busy_req: got req=%b stall=%b want 0/0", bus_req, stall); end
      @(posedge clk); #1;
      bus_ack = 1'b0;
      @(negedge clk);
      exp_rd = 32'h0;
      checks++; if (data_mem_read_data !== exp_rd || fault !== 1'b0 || bus_req !== 1'b0) begin
         errors++; $display("FAIL rst_busy_late_ack: got rd=%h fault=%b req=%b want 0/0/0",
                            data_mem_read_data, fault, bus_req);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         int s, b, f; logic [31:0] rd, wo, ao; logic fd, we_o, st; logic [3:0] be;
         logic we, err, spur, ok, acked, flt;
         logic [2:0] f3;
         logic [31:0] addr, wd, rdata;
         int ack_at, e_busy;
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         addr = $urandom() & 32'h0000_FFFF;
         wd = $urandom();
         rdata = $urandom();
         ack_at = $urandom_range(0, 5);
         err = ($urandom_range(0, 5) == 0);
         spur = 1'($urandom_range(0, 1));
         run_access(we, addr, wd, f3, ack_at, err, rdata, spur,
                    s, b, f, rd, fd, be, wo, ao, we_o, st);
         ok = is_legal(f3) && is_aligned(f3, addr);
         if (!ok) begin
            checks++; if (s != 0 || b != 0 || f != 1) begin errors++;
               $display("FAIL rnd%0d_reject: got stall=%0d busy=%0d faults=%0d want 0/0/1", i, s, b, f); end
            checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rnd%0d_reject_rd: got %h want %h", i, rd, exp_rd); end
         end else begin
            acked  = (ack_at >= 1) && (ack_at <= int'(TMO));
            e_busy = acked ? ack_at : int'(TMO);
            flt    = !acked || err;
            if (!we) exp_rd = flt ? 32'h0 : model_load(f3, addr, rdata);
            checks++; if (s != e_busy + 1 || b != e_busy) begin errors++;
               $display("FAIL rnd%0d_timing: got stall=%0d busy=%0d want %0d/%0d", i, s, b, e_busy + 1, e_busy); end
            checks++; if (f != int'(flt) || fd !== flt) begin errors++;
               $display("FAIL rnd%0d_fault: got pulses=%0d done=%b want %0d", i, f, fd, flt); end
            checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rnd%0d_rd: got %h want %h", i, rd, exp_rd); end
            checks++; if (ao !== (addr & ~32'd3) || we_o !== we || st !== 1'b1) begin errors++;
               $display("FAIL rnd%0d_bus: got addr=%h we=%b stable=%b want %h/%b/1", i, ao, we_o, st, addr & ~32'd3, we); end
            if (we) begin
               checks++; if (be !== model_be(f3, addr) || wo !== model_wdata(f3, wd)) begin errors++;
                  $display("FAIL rnd%0d_lanes: got be=%b wdata=%h want %b/%h", i, be, wo,
                           model_be(f3, addr), model_wdata(f3, wd)); end
            end
         end
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      exp_rd = 32'h0;
      reset = 1'b1;
      test_reset();
      test_load_basic();
      test_load_ext();
      test_store();
      test_misaligned();
      test_timeout();
      test_bus_err();
      test_reset_busy();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
